// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frame sequencer between the AXI-Stream ports and the FFT core's shared
//   sample memory. It loads one frame of N = 2**FFT_LOG2 samples into memory,
//   zero-padding if tlast arrives early. It then pulses fft_start, waits for
//   fft_done, and streams memory addresses 0..N-1 out on the master stream.
//   Only one frame is in flight at a time.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_axis_{tdata,tvalid,tlast}    input sample stream
//   s_axis_tready                  high only while loading a frame
//   m_axis_{tdata,tvalid,tlast}    output sample stream (tlast on sample N-1)
//   m_axis_tready                  output backpressure
//   mem_wr_{en,addr,data}          sample memory write port
//   mem_rd_{en,addr}, mem_rd_data  sample memory read port (1-cycle latency)
//   fft_start / fft_done           core handshake pulses
//   err_tlast_early                pulse: tlast seen before sample N-1
//   err_tlast_missing              pulse: sample N-1 accepted without tlast
//   frame_cnt                      completed output frames (wraps)
module fft_frame_ctrl #(
    parameter int FFT_LOG2 = 10,
    parameter int VLW_WDT  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VLW_WDT-1:0]  s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [VLW_WDT-1:0]  m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                mem_wr_en,
    output logic [FFT_LOG2-1:0] mem_wr_addr,
    output logic [VLW_WDT-1:0]  mem_wr_data,
    output logic                mem_rd_en,
    output logic [FFT_LOG2-1:0] mem_rd_addr,
    input  logic [VLW_WDT-1:0]  mem_rd_data,
    output logic                fft_start,
    input  logic                fft_done,
    output logic                err_tlast_early,
    output logic                err_tlast_missing,
    output logic [15:0]         frame_cnt
);

    localparam logic [FFT_LOG2-1:0] LAST_ADDR = {FFT_LOG2{1'b1}};
    localparam logic [FFT_LOG2-1:0] ADDR_ONE  = FFT_LOG2'(1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_PAD,
        S_START,
        S_COMPUTE,
        S_UNLOAD
    } state_e;

    state_e                state_q;
    logic [FFT_LOG2-1:0]   wcnt_q;        // next write address
    logic [FFT_LOG2-1:0]   rcnt_q;        // next read address
    logic                  rd_all_q;      // terminal flag: all N reads issued
    logic                  rd_pend_q;     // read issued last cycle, data arrives now
    logic [FFT_LOG2-1:0]   ocnt_q;        // address of the current output beat
    logic [VLW_WDT-1:0]    buf0_q;        // skid buffer head (drives m_axis_tdata)
    logic [VLW_WDT-1:0]    buf1_q;
    logic [1:0]            occ_q;         // skid buffer occupancy, 0..2
    logic                  tready_q;
    logic                  fft_start_q;
    logic                  err_early_q;
    logic                  err_missing_q;
    logic [15:0]           frame_cnt_q;

    logic                  in_beat;
    logic                  pad_wr;
    logic                  out_valid;
    logic                  out_pop;
    logic                  last_pop;
    logic                  rd_window;
    logic [1:0]            occ_eff;
    logic                  rd_issue;

    // NOTE: always_comb assigns every output unconditionally so no latch is inferred.
    always_comb begin
        in_beat   = (state_q == S_LOAD) && s_axis_tvalid && tready_q;
        pad_wr    = (state_q == S_PAD);
        out_valid = (occ_q != 2'd0);
        out_pop   = out_valid && m_axis_tready;
        last_pop  = out_pop && (ocnt_q == LAST_ADDR);
        // The first read is issued in the fft_done cycle itself so that tvalid
        // can rise two cycles later.
        rd_window = ((state_q == S_COMPUTE) && fft_done) ||
                    ((state_q == S_UNLOAD) && !rd_all_q);
        // Occupancy once this cycle's pop and in-flight data have settled.
        // A new read lands a cycle later, so one free slot must remain even
        // if the consumer stalls from now on.
        occ_eff   = occ_q + {1'b0, rd_pend_q} - {1'b0, out_pop};
        rd_issue  = rd_window && (occ_eff <= 2'd1);
    end

    assign s_axis_tready     = tready_q;
    assign mem_wr_en         = in_beat || pad_wr;
    assign mem_wr_addr       = wcnt_q;
    assign mem_wr_data       = in_beat ? s_axis_tdata : '0;
    assign mem_rd_en         = rd_issue;
    assign mem_rd_addr       = rcnt_q;
    assign m_axis_tdata      = buf0_q;
    assign m_axis_tvalid     = out_valid;
    assign m_axis_tlast      = out_valid && (ocnt_q == LAST_ADDR);
    assign fft_start         = fft_start_q;
    assign err_tlast_early   = err_early_q;
    assign err_tlast_missing = err_missing_q;
    assign frame_cnt         = frame_cnt_q;

    // NOTE: sequential state uses non-blocking assignments only; a later
    // assignment in the same block overrides an earlier default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_LOAD;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            rd_all_q      <= 1'b0;
            rd_pend_q     <= 1'b0;
            ocnt_q        <= '0;
            // NOTE: the skid buffer is reset because it drives m_axis_tdata,
            // which must read 0 during reset; the external sample memory is not.
            buf0_q        <= '0;
            buf1_q        <= '0;
            occ_q         <= 2'd0;
            tready_q      <= 1'b0;
            fft_start_q   <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            fft_start_q   <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;

            case (state_q)
                S_LOAD: begin
                    tready_q <= 1'b1;
                    if (in_beat) begin
                        wcnt_q <= wcnt_q + ADDR_ONE;
                        if (wcnt_q == LAST_ADDR) begin
                            state_q       <= S_START;
                            tready_q      <= 1'b0;
                            fft_start_q   <= 1'b1;
                            err_missing_q <= !s_axis_tlast;
                        end else if (s_axis_tlast) begin
                            state_q     <= S_PAD;
                            tready_q    <= 1'b0;
                            err_early_q <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    wcnt_q <= wcnt_q + ADDR_ONE;
                    if (wcnt_q == LAST_ADDR) begin
                        state_q     <= S_START;
                        fft_start_q <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (fft_done) begin
                        state_q <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (last_pop) begin
                        state_q     <= S_LOAD;
                        tready_q    <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase

            // Read side: counters wrap to 0 naturally after N-1.
            rd_pend_q <= rd_issue;
            if (rd_issue) begin
                rcnt_q <= rcnt_q + ADDR_ONE;
                if (rcnt_q == LAST_ADDR) begin
                    rd_all_q <= 1'b1;
                end
            end
            if (last_pop) begin
                rd_all_q <= 1'b0;
            end
            if (out_pop) begin
                ocnt_q <= ocnt_q + ADDR_ONE;
            end

            // Two-entry skid buffer: push = returning read data, pop = handshake.
            case ({rd_pend_q, out_pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        buf0_q <= mem_rd_data;
                    end else begin
                        buf1_q <= mem_rd_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= mem_rd_data;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= mem_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
//   Self-checking bench for fft_frame_ctrl with FFT_LOG2=4 (N=16).
//   Models the sample memory read port (data = address ^ 0xA5 plus a fixed
//   upper pattern) and the FFT core (fft_done 20 cycles after fft_start).
//   Expected memory writes and output beats are queued when stimulus is
//   driven and compared when the DUT produces them.
module tb_fft_frame_ctrl;

    localparam int LOG2 = 4;
    localparam int N    = 16;
    localparam int W    = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic            mem_wr_en;
    logic [LOG2-1:0] mem_wr_addr;
    logic [W-1:0]    mem_wr_data;
    logic            mem_rd_en;
    logic [LOG2-1:0] mem_rd_addr;
    logic [W-1:0]    mem_rd_data = '0;
    logic            fft_start;
    logic            fft_done;
    logic            err_tlast_early;
    logic            err_tlast_missing;
    logic [15:0]     frame_cnt;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.FFT_LOG2(LOG2), .VLW_WDT(W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_data       (mem_rd_data),
        .fft_start         (fft_start),
        .fft_done          (fft_done),
        .err_tlast_early   (err_tlast_early),
        .err_tlast_missing (err_tlast_missing),
        .frame_cnt         (frame_cnt)
    );

    typedef struct packed {
        logic [LOG2-1:0] addr;
        logic [W-1:0]    data;
    } wr_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } out_t;

    wr_t  wr_q[$];
    out_t out_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rd_val(input logic [LOG2-1:0] a);
        logic [7:0] b;
        b = {4'h0, a} ^ 8'hA5;
        return {16'hF00D, 40'h0, b};
    endfunction

    // Memory read port: data valid exactly one cycle after mem_rd_en.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? rd_val(mem_rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // Output ready driver: duty in percent, 100 means held high.
    int duty = 100;
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (duty >= 100) ? 1'b1 : (int'($urandom_range(99)) < duty);
        end
    end

    // FFT core model. A reset while it is busy makes its fft_done "late":
    // no output is expected and tvalid must stay low.
    int n_resets = 0;
    initial begin
        int r0;
        fft_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && fft_start) begin
                r0 = n_resets;
                repeat (20) @(posedge clk);
                #1;
                fft_done = 1'b1;
                if (r0 == n_resets) begin
                    for (int i = 0; i < N; i++) begin
                        out_q.push_back('{data: rd_val(LOG2'(i)), last: (i == N - 1)});
                    end
                end
                @(posedge clk);
                #1;
                fft_done = 1'b0;
                @(negedge clk);
                check(r0 == n_resets ? "tvalid_done_p1" : "late_done_p1", m_axis_tvalid, 1'b0);
                @(negedge clk);
                check(r0 == n_resets ? "tvalid_done_p2" : "late_done_p2", m_axis_tvalid, r0 == n_resets);
            end
        end
    end

    // fft_start pulse counter (every cycle it is high counts).
    int n_start_cyc = 0;
    always @(negedge clk) begin
        if (rst_n && fft_start) n_start_cyc++;
    end

    // Memory write monitor.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_wr_en) begin
            check("wr_expected", wr_q.size() != 0, 1'b1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("wr_addr", mem_wr_addr, e.addr);
                check("wr_data", mem_wr_data, e.data);
            end
        end
    end

    // Output stream monitor.
    logic [W-1:0] stall_data;
    logic         stall_last;
    logic         stalled = 1'b0;
    logic         pend_fc = 1'b0;
    int           beats = 0;
    int           frames_done = 0;
    logic [15:0]  exp_fc = 16'd0;
    always @(negedge clk) begin
        out_t e;
        if (!rst_n) begin
            stalled = 1'b0;
            pend_fc = 1'b0;
            beats   = 0;
            exp_fc  = 16'd0;
        end else begin
            if (pend_fc) begin
                check("frame_cnt", frame_cnt, exp_fc);
                check("s_ready_after_unload", s_axis_tready, 1'b1);
                pend_fc = 1'b0;
            end
            if (stalled) begin
                check("stall_valid", m_axis_tvalid, 1'b1);
                check("stall_data", m_axis_tdata, stall_data);
                check("stall_last", m_axis_tlast, stall_last);
            end
            if (duty >= 100 && beats > 0 && beats < N) begin
                check("no_bubble", m_axis_tvalid, 1'b1);
            end
            stalled    = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                check("out_expected", out_q.size() != 0, 1'b1);
                if (out_q.size() != 0) begin
                    e = out_q.pop_front();
                    check("out_data", m_axis_tdata, e.data);
                    check("out_last", m_axis_tlast, e.last);
                end
                beats++;
                if (beats == N) begin
                    beats = 0;
                    exp_fc++;
                    frames_done++;
                    pend_fc = 1'b1;
                end
            end
        end
    end

    int frames_expected = 0;

    // Drives nb beats (tlast on beat last_at, -1 for none); called and
    // returns at posedge+1.
    task automatic send_frame(input int nb, input int last_at, input bit seq);
        logic [W-1:0] d;
        bit           ok;
        int           waited;
        int           k;
        for (int i = 0; i < nb; i++) begin
            d = seq ? 64'(i) : {$urandom, $urandom};
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == last_at);
            wr_q.push_back('{addr: LOG2'(i), data: d});
            waited = 0;
            do begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk);
                #1;
                waited++;
                if (!ok && waited > 3000) begin
                    $display("FAIL in_timeout: s_axis_tready stuck low at beat %0d", i);
                    $fatal(1, "input handshake timeout");
                end
            end while (!ok);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        for (int a = nb; a < N; a++) begin
            wr_q.push_back('{addr: LOG2'(a), data: '0});
        end
        @(negedge clk);
        check("err_early", err_tlast_early, (last_at >= 0) && (last_at < N - 1));
        check("err_missing", err_tlast_missing, (nb == N) && (last_at != N - 1));
        k = 1;
        while (!fft_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("start_delay", k, (nb < N) ? (N - nb + 1) : 1);
        frames_expected++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained();
        int w;
        w = 0;
        while (frames_done != frames_expected && w < 3000) begin
            @(posedge clk);
            w++;
        end
        check("drain", frames_done, frames_expected);
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ctrl", {s_axis_tready, m_axis_tvalid, m_axis_tlast, mem_wr_en, mem_rd_en,
                           fft_start, err_tlast_early, err_tlast_missing}, '0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_addr", {mem_wr_addr, mem_rd_addr}, '0);
        check("rst_wdata", mem_wr_data, '0);
        check("rst_frame_cnt", frame_cnt, '0);

        rst_n = 1'b1;
        #1;
        check("tready_before_edge", s_axis_tready, 1'b0);
        @(posedge clk);
        #1;
        check("tready_after_rst", s_axis_tready, 1'b1);
        check("idle_ctrl", {m_axis_tvalid, mem_wr_en, mem_rd_en, fft_start,
                            err_tlast_early, err_tlast_missing}, '0);

        // Nominal frame, data 0..15, tready held high.
        send_frame(N, N - 1, 1'b1);
        wait_drained();

        // Early tlast on beat 5: zero padding of addresses 6..15.
        send_frame(6, 5, 1'b0);
        wait_drained();

        // Missing tlast.
        send_frame(N, -1, 1'b0);
        wait_drained();

        // Output backpressure at 30% ready duty.
        duty = 30;
        send_frame(N, N - 1, 1'b0);
        wait_drained();
        duty = 100;

        // Asynchronous reset in the middle of COMPUTE.
        send_frame(N, N - 1, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        n_resets++;
        frames_expected--;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", {s_axis_tready, m_axis_tvalid, fft_start, mem_wr_en, mem_rd_en}, '0);
        check("arst_frame_cnt", frame_cnt, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_arst", s_axis_tready, 1'b1);

        // Three frames back to back.
        for (int f = 0; f < 3; f++) begin
            send_frame(N, N - 1, 1'b0);
        end
        wait_drained();
        repeat (3) @(posedge clk);

        check("final_frame_cnt", frame_cnt, 16'd3);
        check("start_pulses", n_start_cyc, 8);
        check("out_q_empty", out_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
